led_bin_allocator: RTL and testbench

//  Stage directly upstream of the LED serial driver. Accepts one frame of BIN_QTY bin amplitudes

---
 rtl/led_bin_allocator.sv | 169 ++++++++++++++++
 tb/tb_led_bin_allocator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bin_allocator.sv
// Splits LEDS LEDs across BIN_QTY bins in proportion to amplitude.
// Sequential sum, restoring division and leftover fix-up; publishes atomically once the driver is idle.
module led_bin_allocator #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int AMP_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIN_QTY*AMP_W-1:0]   amps,
  input  logic [BIN_QTY*24-1:0]      colors,
  input  logic                       led_done,
  output logic [BIN_QTY*24-1:0]      rgb,
  output logic [BIN_QTY*$clog2(LEDS)-1:0] LEDCounts,
  output logic                       out_valid
);

  localparam int CW  = $clog2(LEDS);
  localparam int QW  = $clog2(LEDS + 1);
  localparam int TW  = AMP_W + $clog2(BIN_QTY);
  localparam int NW  = AMP_W + QW;
  localparam int DW  = TW + QW;
  localparam int BIW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
  localparam int SW  = $clog2(QW + 1);

  // A power-of-two LED count would not fit in the CW-bit count fields.
  if ((LEDS & (LEDS - 1)) == 0) begin : g_leds_check
    $error("led_bin_allocator: LEDS must not be a power of two");
  end

  typedef enum logic [2:0] {S_IDLE, S_SUM, S_DIV, S_FIX, S_PUB} state_t;

  state_t                   state_q;
  logic [AMP_W-1:0]         amp_q   [BIN_QTY];
  logic [23:0]              color_q [BIN_QTY];
  logic [CW-1:0]            cnt_q   [BIN_QTY];
  logic [TW-1:0]            total_q;
  logic [AMP_W-1:0]         maxAmp_q;
  logic [BIW-1:0]           maxIdx_q;
  logic [CW-1:0]            sum_q;
  logic [BIW-1:0]           binIdx_q;
  logic [SW-1:0]            step_q;
  logic [NW-1:0]            num_q;
  logic [DW-1:0]            div_q;
  logic [QW-1:0]            quo_q;
  logic                     inReady_q;
  logic                     outValid_q;
  logic [BIN_QTY*24-1:0]    rgb_q;
  logic [BIN_QTY*CW-1:0]    ledCounts_q;

  logic                     divGe_d;
  logic [QW-1:0]            quo_d;
  logic [NW-1:0]            num_d;

  // One restoring step; a zero total forces every quotient bit to 0.
  always_comb begin
    divGe_d = (total_q != '0) && (DW'(num_q) >= div_q);
    quo_d   = {quo_q[QW-2:0], divGe_d};
    num_d   = divGe_d ? (num_q - NW'(div_q)) : num_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      total_q     <= '0;
      maxAmp_q    <= '0;
      maxIdx_q    <= '0;
      sum_q       <= '0;
      binIdx_q    <= '0;
      step_q      <= '0;
      num_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      inReady_q   <= 1'b1;
      outValid_q  <= 1'b0;
      rgb_q       <= '0;
      ledCounts_q <= '0;
      for (int i = 0; i < BIN_QTY; i++) begin
        amp_q[i]   <= '0;
        color_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      outValid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < BIN_QTY; i++) begin
              amp_q[i]   <= amps[i*AMP_W +: AMP_W];
              color_q[i] <= colors[i*24 +: 24];
            end
            total_q   <= '0;
            maxAmp_q  <= '0;
            maxIdx_q  <= '0;
            sum_q     <= '0;
            binIdx_q  <= '0;
            step_q    <= '0;
            inReady_q <= 1'b0;
            state_q   <= S_SUM;
          end
        end
        S_SUM: begin
          total_q <= total_q + TW'(amp_q[binIdx_q]);
          if (amp_q[binIdx_q] > maxAmp_q) begin
            maxAmp_q <= amp_q[binIdx_q];
            maxIdx_q <= binIdx_q;
          end
          if (binIdx_q == BIW'(BIN_QTY - 1)) begin
            binIdx_q <= '0;
            state_q  <= S_DIV;
          end else begin
            binIdx_q <= binIdx_q + 1'b1;
          end
        end
        S_DIV: begin
          if (step_q == '0) begin
            num_q  <= NW'(amp_q[binIdx_q]) * NW'(LEDS);
            div_q  <= DW'(total_q) << (QW - 1);
            quo_q  <= '0;
            step_q <= SW'(1);
          end else begin
            num_q <= num_d;
            div_q <= div_q >> 1;
            quo_q <= quo_d;
            if (step_q == SW'(QW)) begin
              cnt_q[binIdx_q] <= CW'(quo_d);
              sum_q           <= sum_q + CW'(quo_d);
              step_q          <= '0;
              if (binIdx_q == BIW'(BIN_QTY - 1)) begin
                binIdx_q <= '0;
                state_q  <= S_FIX;
              end else begin
                binIdx_q <= binIdx_q + 1'b1;
              end
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
        S_FIX: begin
          if (total_q != '0) begin
            cnt_q[maxIdx_q] <= cnt_q[maxIdx_q] + (CW'(LEDS) - sum_q);
          end
          state_q <= S_PUB;
        end
        S_PUB: begin
          if (led_done) begin
            for (int i = 0; i < BIN_QTY; i++) begin
              ledCounts_q[i*CW +: CW] <= cnt_q[i];
              rgb_q[i*24 +: 24]       <= (cnt_q[i] != '0) ? color_q[i] : 24'd0;
            end
            outValid_q <= 1'b1;
            inReady_q  <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign rgb       = rgb_q;
  assign LEDCounts = ledCounts_q;

endmodule

// File: tb/tb_led_bin_allocator.sv
// Directed self-checking bench for led_bin_allocator with default parameters.
module tb_led_bin_allocator;

  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int AMP_W   = 16;
  localparam int CW      = 6;
  localparam int LAT     = 98;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [BIN_QTY*AMP_W-1:0]  amps;
  logic [BIN_QTY*24-1:0]     colors;
  logic                      led_done;
  logic [BIN_QTY*24-1:0]     rgb;
  logic [BIN_QTY*CW-1:0]     LEDCounts;
  logic                      out_valid;

  int checks = 0;
  int fails  = 0;
  logic busyReady;

  led_bin_allocator #(.LEDS(LEDS), .BIN_QTY(BIN_QTY), .AMP_W(AMP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .amps(amps), .colors(colors), .led_done(led_done), .rgb(rgb),
    .LEDCounts(LEDCounts), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] getCount(input int i);
    return LEDCounts[i*CW +: CW];
  endfunction

  function automatic logic [23:0] getRgb(input int i);
    return rgb[i*24 +: 24];
  endfunction

  function automatic logic [23:0] getColor(input int i);
    return colors[i*24 +: 24];
  endfunction

  task automatic setFrame(input logic [AMP_W-1:0] a [BIN_QTY]);
    for (int i = 0; i < BIN_QTY; i++) begin
      amps[i*AMP_W +: AMP_W] = a[i];
      colors[i*24 +: 24]     = 24'h100000 * (i + 1) + 24'h000101 * (i + 3);
    end
  endtask

  // Offers the frame, then counts edges after the accept edge until out_valid; -1 on timeout.
  task automatic applyStimulus(input int doneAfter, input bit injectBusy, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    led_done = (doneAfter == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
      if (c == doneAfter) led_done = 1'b1;
      if (injectBusy && c == 10) begin
        busyReady = in_ready;
        in_valid  = 1'b1;
        amps      = {BIN_QTY{16'hFFFF}};
      end
      if (injectBusy && c == 12) in_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; led_done = 1'b1; amps = '0; colors = '0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || LEDCounts !== '0 || rgb !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b counts=%h rgb=%h, required 1 0 0 0",
               in_ready, out_valid, LEDCounts, rgb);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || LEDCounts !== '0) begin
      fails++;
      $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b counts=%h, required 1 0 0",
               in_ready, out_valid, LEDCounts);
    end
  endtask

  task automatic test_three_bins;
    logic [AMP_W-1:0] a [BIN_QTY];
    int lat;
    logic [CW-1:0] exp [BIN_QTY];
    for (int i = 0; i < BIN_QTY; i++) begin a[i] = '0; exp[i] = '0; end
    a[0] = 100; a[1] = 100; a[2] = 100;
    exp[0] = 18; exp[1] = 16; exp[2] = 16;
    setFrame(a);
    colors[0*24 +: 24] = 24'hFFFFFF;
    colors[1*24 +: 24] = 24'hF0F0F0;
    colors[2*24 +: 24] = 24'hAAAAAA;
    applyStimulus(0, 1'b0, lat);
    checks++;
    if (lat !== LAT) begin
      fails++;
      $display("[TB] FAIL three_bins_latency: got %0d, required %0d", lat, LAT);
    end
    for (int i = 0; i < BIN_QTY; i++) begin
      checks++;
      if (getCount(i) !== exp[i]) begin
        fails++;
        $display("[TB] FAIL three_bins_count[%0d]: got %0d, required %0d", i, getCount(i), exp[i]);
      end
    end
    checks++;
    if (getRgb(0) !== 24'hFFFFFF || getRgb(1) !== 24'hF0F0F0 || getRgb(2) !== 24'hAAAAAA ||
        rgb[BIN_QTY*24-1:3*24] !== '0) begin
      fails++;
      $display("[TB] FAIL three_bins_rgb: got %h, required FFFFFF/F0F0F0/AAAAAA then zeros", rgb);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL three_bins_after_pulse: out_valid=%b in_ready=%b, required 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_single_bin;
    logic [AMP_W-1:0] a [BIN_QTY];
    int lat;
    for (int i = 0; i < BIN_QTY; i++) a[i] = '0;
    a[5] = 1;
    setFrame(a);
    applyStimulus(0, 1'b0, lat);
    checks++;
    if (lat !== LAT) begin
      fails++;
      $display("[TB] FAIL single_bin_latency: got %0d, required %0d", lat, LAT);
    end
    for (int i = 0; i < BIN_QTY; i++) begin
      checks++;
      if (getCount(i) !== ((i == 5) ? 6'd50 : 6'd0) ||
          getRgb(i) !== ((i == 5) ? getColor(5) : 24'd0)) begin
        fails++;
        $display("[TB] FAIL single_bin[%0d]: count=%0d rgb=%h, required %0d %h", i, getCount(i),
                 getRgb(i), (i == 5) ? 50 : 0, (i == 5) ? getColor(5) : 24'd0);
      end
    end
  endtask

  task automatic test_all_zero;
    logic [AMP_W-1:0] a [BIN_QTY];
    int lat;
    for (int i = 0; i < BIN_QTY; i++) a[i] = '0;
    setFrame(a);
    applyStimulus(0, 1'b0, lat);
    checks++;
    if (lat !== LAT) begin
      fails++;
      $display("[TB] FAIL all_zero_latency: got %0d, required %0d", lat, LAT);
    end
    checks++;
    if (LEDCounts !== '0 || rgb !== '0) begin
      fails++;
      $display("[TB] FAIL all_zero_outputs: counts=%h rgb=%h, required 0 0", LEDCounts, rgb);
    end
  endtask

  task automatic test_all_full;
    logic [AMP_W-1:0] a [BIN_QTY];
    int lat;
    int total;
    for (int i = 0; i < BIN_QTY; i++) a[i] = 16'hFFFF;
    setFrame(a);
    applyStimulus(0, 1'b0, lat);
    total = 0;
    for (int i = 0; i < BIN_QTY; i++) begin
      total += int'(getCount(i));
      checks++;
      if (getCount(i) !== ((i == 0) ? 6'd6 : 6'd4) || getRgb(i) !== getColor(i)) begin
        fails++;
        $display("[TB] FAIL all_full[%0d]: count=%0d rgb=%h, required %0d %h", i, getCount(i),
                 getRgb(i), (i == 0) ? 6 : 4, getColor(i));
      end
    end
    checks++;
    if (total !== LEDS) begin
      fails++;
      $display("[TB] FAIL all_full_sum: got %0d, required %0d", total, LEDS);
    end
  endtask

  task automatic test_back_to_back;
    logic [AMP_W-1:0] a [BIN_QTY];
    int lat;
    for (int i = 0; i < BIN_QTY; i++) a[i] = '0;
    a[2] = 7; a[9] = 3;
    setFrame(a);
    busyReady = 1'bx;
    applyStimulus(117, 1'b1, lat);
    checks++;
    if (lat !== LAT + 20) begin
      fails++;
      $display("[TB] FAIL held_latency: got %0d, required %0d", lat, LAT + 20);
    end
    checks++;
    if (busyReady !== 1'b0) begin
      fails++;
      $display("[TB] FAIL busy_in_ready: got %b, required 0", busyReady);
    end
    for (int i = 0; i < BIN_QTY; i++) begin
      checks++;
      if (getCount(i) !== ((i == 2) ? 6'd35 : (i == 9) ? 6'd15 : 6'd0)) begin
        fails++;
        $display("[TB] FAIL held_count[%0d]: got %0d, required %0d", i, getCount(i),
                 (i == 2) ? 35 : (i == 9) ? 15 : 0);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [AMP_W-1:0] a [BIN_QTY];
    bit sawPulse;
    for (int i = 0; i < BIN_QTY; i++) a[i] = 16'd10 * (i + 1);
    setFrame(a);
    @(negedge clk); in_valid = 1'b1; led_done = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (LEDCounts !== '0 || rgb !== '0 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset_outputs: counts=%h rgb=%h out_valid=%b, required 0 0 0",
               LEDCounts, rgb, out_valid);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reset_ready: got %b, required 1", in_ready);
    end
    sawPulse = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (out_valid) sawPulse = 1'b1;
    end
    checks++;
    if (sawPulse !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset_no_pulse: got pulse=%b, required 0", sawPulse);
    end
  endtask

  initial begin
    test_reset;
    test_three_bins;
    test_single_bin;
    test_all_zero;
    test_all_full;
    test_back_to_back;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
